sram_like_arb: RTL and testbench

Two-requester arbiter that shares the single data-side SRAM-like port of the CPU-to-AXI bridge between two SRAM-like masters: m0 is the uncached/MMIO path, m1 is the data-cache refill/writeback path. It selects one request per handshake, holds that selection stable until the slave accepts it, and records the owner of every accepted transaction in an in-order tag FIFO. Responses are steered back using that FIFO, because the slave port returns `data_ok` strictly in acceptance order.

---
 rtl/sram_like_arb.sv | 178 +++++++++++++++++
 tb/tb_sram_like_arb.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sram_like_arb                                              |
// | Description : Two-master arbiter for the bridge's SRAM-like data port.   |
// |               m0 = uncached/MMIO path, m1 = D-cache refill/writeback.    |
// |               The grant is held until the slave accepts. The owner of    |
// |               each accepted transaction goes into an in-order tag FIFO   |
// |               that steers data_ok back to the right master.              |
// | Options     : SRAM_ARB_RR_EN defined   -> round-robin on contention      |
// |               SRAM_ARB_RR_EN undefined -> fixed priority, m1 over m0     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sram_like_arb #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    // master 0 (uncached / MMIO)
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_wdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    output logic [31:0] m0_rdata,
    // master 1 (D-cache)
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_wdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m1_rdata,
    // bridge data port
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    // sticky ordering error
    output logic        ord_err
);

    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]   c_FULL_CNT = (c_PTR_W + 1)'(DEPTH);

    logic                 w_grant;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_head;

    logic                 r_locked;
    logic                 r_lock_id;
    logic                 r_ord_err;
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_PTR_W:0]     r_count;
    logic                 r_tag [DEPTH];

`ifdef SRAM_ARB_RR_EN
    logic                 r_last;
`endif

    // Grant: a pending (locked) request keeps its master; otherwise sole requester or priority rule
    always_comb begin
        w_grant = 1'b0;
        if (r_locked) begin
            w_grant = r_lock_id;
        end else if (m0_req && m1_req) begin
`ifdef SRAM_ARB_RR_EN
            w_grant = ~r_last;
`else
            w_grant = 1'b1;
`endif
        end else if (m1_req) begin
            w_grant = 1'b1;
        end
    end

    assign w_full   = (r_count == c_FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_head   = r_tag[r_rptr];

    // Request path: full blocks the request even if a pop happens this cycle
    assign s_req    = (m0_req | m1_req) & ~w_full & ~reset;
    assign s_wr     = w_grant ? m1_wr    : m0_wr;
    assign s_size   = w_grant ? m1_size  : m0_size;
    assign s_addr   = w_grant ? m1_addr  : m0_addr;
    assign s_wstrb  = w_grant ? m1_wstrb : m0_wstrb;
    assign s_wdata  = w_grant ? m1_wdata : m0_wdata;

    assign w_accept   = s_req & s_addr_ok;
    assign m0_addr_ok = w_accept & ~w_grant;
    assign m1_addr_ok = w_accept &  w_grant;

    // Response path: a data_ok with nothing outstanding is dropped and flagged
    assign w_pop      = s_data_ok & ~w_empty & ~reset;
    assign m0_data_ok = w_pop & ~w_head;
    assign m1_data_ok = w_pop &  w_head;
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;
    assign ord_err    = r_ord_err & ~reset;

    // Lock the grant while a presented request waits for addr_ok
    always_ff @(posedge clk) begin
        if (reset) begin
            r_locked  <= 1'b0;
            r_lock_id <= 1'b0;
        end else if (w_accept) begin
            r_locked  <= 1'b0;
        end else if (s_req) begin
            r_locked  <= 1'b1;
            r_lock_id <= w_grant;
        end
    end

`ifdef SRAM_ARB_RR_EN
    // Remember the last accepted master so the other one wins the next contest
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_grant;
        end
    end
`endif

    // Tag storage carries no reset; entries are only read when the count says they are valid
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag[r_wptr] <= w_grant;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flag for a response that has no outstanding transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ord_err <= 1'b0;
        end else if (s_data_ok && w_empty) begin
            r_ord_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sram_like_arb                                           |
// | Description : Self-checking bench for sram_like_arb. A queue-based       |
// |               model of outstanding owners predicts every output.         |
// |               Honours SRAM_ARB_RR_EN the same way the design does.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sram_like_arb;

    localparam int DEPTH = 4;
`ifdef SRAM_ARB_RR_EN
    localparam bit c_RR_EN = 1'b1;
`else
    localparam bit c_RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_addr_ok, s_data_ok;
    logic        ord_err;

    sram_like_arb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
        .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
        .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
        .s_wstrb(s_wstrb), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .ord_err(ord_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: owners of accepted-but-unanswered transactions, in order
    int  q[$];
    int  held = -1;      // master whose request was presented but not yet accepted
    int  last = 1;       // most recent accepted master
    bit  err  = 1'b0;
    bit  evaluated = 1'b0;

    bit  e_sreq, e_ao0, e_ao1, e_do0, e_do1, e_err, e_pop;
    int  e_grant;
    logic [70:0] e_fields;

    function automatic void model_eval();
        int n;
        n = q.size();
        e_sreq = (m0_req || m1_req) && (n < DEPTH) && !reset;
        if (held >= 0)              e_grant = held;
        else if (m0_req && m1_req)  e_grant = c_RR_EN ? ((last == 0) ? 1 : 0) : 1;
        else                        e_grant = m1_req ? 1 : 0;
        e_ao0 = e_sreq && s_addr_ok && (e_grant == 0);
        e_ao1 = e_sreq && s_addr_ok && (e_grant == 1);
        e_pop = s_data_ok && !reset && (n > 0);
        e_do0 = e_pop && (q[0] == 0);
        e_do1 = e_pop && (q[0] == 1);
        e_err = err && !reset;
        e_fields = (e_grant == 1) ? {m1_wr, m1_size, m1_addr, m1_wstrb, m1_wdata}
                                  : {m0_wr, m0_size, m0_addr, m0_wstrb, m0_wdata};
    endfunction

    function automatic void model_commit();
        if (reset) begin
            q.delete();
            held = -1;
            last = 1;
            err  = 1'b0;
        end else begin
            if (s_data_ok && q.size() == 0) err = 1'b1;
            if (e_pop) void'(q.pop_front());
            if (e_ao0 || e_ao1) begin
                q.push_back(e_grant);
                held = -1;
                last = e_grant;
            end else if (e_sreq) begin
                held = e_grant;
            end
        end
    endfunction

    // Advance to the next cycle's drive point, retiring the previous cycle into the model
    task automatic cyc();
        if (evaluated) model_commit();
        evaluated = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Let the cycle's inputs settle and form expectations at the falling edge
    task automatic settle();
        @(negedge clk);
        model_eval();
        evaluated = 1'b1;
    endtask

    task automatic idle();
        reset = 1'b0;
        m0_req = 1'b0; m0_wr = 1'b0; m0_size = 2'd2; m0_addr = '0; m0_wstrb = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_size = 2'd2; m1_addr = '0; m1_wstrb = '0; m1_wdata = '0;
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
    endtask

    task automatic do_reset();
        cyc(); idle(); reset = 1'b1; settle();
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 16 && q.size() > 0; k++) begin
            cyc(); idle(); s_data_ok = 1'b1; s_rdata = $urandom; settle();
            checks++;
            if ({m0_data_ok, m1_data_ok} !== {e_do0, e_do1}) begin
                failures++;
                $display("FAIL drain_data_ok: got m0=%b m1=%b want m0=%b m1=%b", m0_data_ok, m1_data_ok, e_do0, e_do1);
            end
        end
        if (q.size() > 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout: got %0d outstanding want 0", q.size());
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            cyc(); idle(); reset = 1'b1; m0_req = 1'b1; m1_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1;
            settle();
            checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL reset_s_req: got %b want 0", s_req); end
            checks++; if ({m0_addr_ok, m1_addr_ok} !== 2'b00) begin failures++; $display("FAIL reset_addr_ok: got %b want 00", {m0_addr_ok, m1_addr_ok}); end
            checks++; if ({m0_data_ok, m1_data_ok} !== 2'b00) begin failures++; $display("FAIL reset_data_ok: got %b want 00", {m0_data_ok, m1_data_ok}); end
            checks++; if (ord_err !== 1'b0) begin failures++; $display("FAIL reset_ord_err: got %b want 0", ord_err); end
        end
        cyc(); idle(); settle();
        checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL post_reset_s_req: got %b want 0", s_req); end
        checks++; if (ord_err !== 1'b0) begin failures++; $display("FAIL post_reset_ord_err: got %b want 0", ord_err); end
    endtask

    task automatic test_single_read();
        for (int c = 0; c < 4; c++) begin
            cyc(); idle();
            if (c == 0) begin
                m0_req = 1'b1; m0_addr = 32'h1fc0_0000; s_addr_ok = 1'b1;
            end
            if (c == 3) begin
                s_data_ok = 1'b1; s_rdata = 32'hdeadbeef;
            end
            settle();
            checks++; if (m1_data_ok !== 1'b0) begin failures++; $display("FAIL single_m1_data_ok c%0d: got %b want 0", c, m1_data_ok); end
            if (c == 0) begin
                checks++; if (m0_addr_ok !== 1'b1) begin failures++; $display("FAIL single_addr_ok: got %b want 1", m0_addr_ok); end
                checks++; if (s_addr !== 32'h1fc0_0000 || s_wr !== 1'b0) begin failures++; $display("FAIL single_s_addr: got %h wr=%b want 1fc00000 wr=0", s_addr, s_wr); end
            end else if (c == 3) begin
                checks++; if (m0_data_ok !== 1'b1) begin failures++; $display("FAIL single_data_ok: got %b want 1", m0_data_ok); end
                checks++; if (m0_rdata !== 32'hdeadbeef) begin failures++; $display("FAIL single_rdata: got %h want deadbeef", m0_rdata); end
            end else begin
                checks++; if (m0_data_ok !== 1'b0) begin failures++; $display("FAIL single_early_data_ok c%0d: got %b want 0", c, m0_data_ok); end
            end
        end
    endtask

    task automatic test_lock();
        for (int c = 0; c < 5; c++) begin
            cyc(); idle();
            if (c <= 3) begin m0_req = 1'b1; m0_addr = 32'h0000_1000; end
            if (c >= 1) begin m1_req = 1'b1; m1_addr = 32'h0000_2000; m1_wr = 1'b1; end
            s_addr_ok = (c >= 3);
            settle();
            if (c <= 3) begin
                checks++; if (s_addr !== 32'h0000_1000) begin failures++; $display("FAIL lock_s_addr c%0d: got %h want 00001000", c, s_addr); end
                checks++; if (m1_addr_ok !== 1'b0) begin failures++; $display("FAIL lock_m1_addr_ok c%0d: got %b want 0", c, m1_addr_ok); end
                checks++; if (m0_addr_ok !== (c == 3)) begin failures++; $display("FAIL lock_m0_addr_ok c%0d: got %b want %b", c, m0_addr_ok, c == 3); end
            end else begin
                checks++; if (s_addr !== 32'h0000_2000 || m1_addr_ok !== 1'b1) begin failures++; $display("FAIL lock_m1_grant: got addr=%h ok=%b want 00002000 ok=1", s_addr, m1_addr_ok); end
            end
        end
        drain();
    endtask

    task automatic test_contention();
        int exp_win [4];
        int got;
        exp_win = c_RR_EN ? '{0, 1, 0, 1} : '{1, 1, 1, 1};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            cyc(); idle();
            m0_req = 1'b1; m0_addr = 32'h100 + c; m1_req = 1'b1; m1_addr = 32'h200 + c; s_addr_ok = 1'b1;
            settle();
            got = m1_addr_ok ? 1 : (m0_addr_ok ? 0 : -1);
            checks++; if (got !== exp_win[c] || (m0_addr_ok && m1_addr_ok)) begin failures++; $display("FAIL contention_winner #%0d: got %0d want %0d", c, got, exp_win[c]); end
        end
        drain();
    endtask

    task automatic test_full();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            cyc(); idle();
            m0_req = 1'b1; m0_addr = 32'h4000 + 4 * c; s_addr_ok = 1'b1;
            if (c >= 4) m0_addr = 32'h4010;
            s_data_ok = (c == 5);
            settle();
            if (c < 4) begin
                checks++; if (m0_addr_ok !== 1'b1) begin failures++; $display("FAIL full_fill #%0d: got %b want 1", c, m0_addr_ok); end
            end else if (c < 6) begin
                checks++; if (s_req !== 1'b0 || m0_addr_ok !== 1'b0) begin failures++; $display("FAIL full_block c%0d: got s_req=%b ok=%b want 0 0", c, s_req, m0_addr_ok); end
                if (c == 5) begin
                    checks++; if (m0_data_ok !== 1'b1) begin failures++; $display("FAIL full_pop: got %b want 1", m0_data_ok); end
                end
            end else begin
                checks++; if (s_req !== 1'b1 || m0_addr_ok !== 1'b1) begin failures++; $display("FAIL full_resume: got s_req=%b ok=%b want 1 1", s_req, m0_addr_ok); end
            end
        end
        drain();
    endtask

    task automatic test_ordering();
        int seq [3];
        seq = '{1, 0, 1};
        for (int c = 0; c < 3; c++) begin
            cyc(); idle(); s_addr_ok = 1'b1;
            if (seq[c] == 1) m1_req = 1'b1; else m0_req = 1'b1;
            settle();
            checks++; if ({m1_addr_ok, m0_addr_ok} !== ((seq[c] == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL order_accept #%0d: got m1=%b m0=%b want owner %0d", c, m1_addr_ok, m0_addr_ok, seq[c]); end
        end
        for (int c = 0; c < 3; c++) begin
            cyc(); idle(); s_data_ok = 1'b1; s_rdata = 32'hA5A5_0000 + c; settle();
            checks++; if ({m1_data_ok, m0_data_ok} !== ((seq[c] == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL order_resp #%0d: got m1=%b m0=%b want owner %0d", c, m1_data_ok, m0_data_ok, seq[c]); end
        end
    endtask

    task automatic test_errors_and_reset();
        drain();
        cyc(); idle(); s_data_ok = 1'b1; settle();
        checks++; if ({m0_data_ok, m1_data_ok} !== 2'b00) begin failures++; $display("FAIL err_no_route: got %b want 00", {m0_data_ok, m1_data_ok}); end
        for (int c = 0; c < 3; c++) begin
            cyc(); idle(); settle();
            checks++; if (ord_err !== 1'b1) begin failures++; $display("FAIL err_sticky c%0d: got %b want 1", c, ord_err); end
        end
        // leave two transactions outstanding, then reset
        for (int c = 0; c < 2; c++) begin
            cyc(); idle(); m1_req = 1'b1; s_addr_ok = 1'b1; settle();
        end
        do_reset();
        checks++; if (ord_err !== 1'b0) begin failures++; $display("FAIL err_during_reset: got %b want 0", ord_err); end
        cyc(); idle(); settle();
        checks++; if (ord_err !== 1'b0) begin failures++; $display("FAIL err_after_reset: got %b want 0", ord_err); end
        // a flushed FIFO accepts exactly DEPTH more before blocking
        for (int c = 0; c <= DEPTH; c++) begin
            cyc(); idle(); m0_req = 1'b1; m0_addr = 32'h8000 + c; s_addr_ok = 1'b1; settle();
            checks++; if (m0_addr_ok !== (c < DEPTH)) begin failures++; $display("FAIL reset_flush #%0d: got %b want %b", c, m0_addr_ok, c < DEPTH); end
        end
        drain();
    endtask

    task automatic test_random();
        bit act0 = 1'b0, act1 = 1'b0;
        logic [70:0] got_fields;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            reset = ($urandom_range(0, 299) == 0);
            if (!act0 && ($urandom % 3 == 0)) begin
                act0 = 1'b1; m0_wr = $urandom; m0_size = 2'($urandom_range(0, 2));
                m0_addr = $urandom; m0_wstrb = 4'($urandom); m0_wdata = $urandom;
            end
            if (!act1 && ($urandom % 3 == 0)) begin
                act1 = 1'b1; m1_wr = $urandom; m1_size = 2'($urandom_range(0, 2));
                m1_addr = $urandom; m1_wstrb = 4'($urandom); m1_wdata = $urandom;
            end
            m0_req = act0; m1_req = act1;
            s_addr_ok = $urandom;
            s_data_ok = (q.size() > 0) ? ($urandom % 3 == 0) : ($urandom_range(0, 199) == 0);
            s_rdata = $urandom;
            settle();
            checks++; if (s_req !== e_sreq) begin failures++; $display("FAIL rand_s_req c%0d: got %b want %b", c, s_req, e_sreq); end
            checks++; if ({m0_addr_ok, m1_addr_ok} !== {e_ao0, e_ao1}) begin failures++; $display("FAIL rand_addr_ok c%0d: got %b%b want %b%b", c, m0_addr_ok, m1_addr_ok, e_ao0, e_ao1); end
            checks++; if ({m0_data_ok, m1_data_ok} !== {e_do0, e_do1}) begin failures++; $display("FAIL rand_data_ok c%0d: got %b%b want %b%b", c, m0_data_ok, m1_data_ok, e_do0, e_do1); end
            checks++; if (ord_err !== e_err) begin failures++; $display("FAIL rand_ord_err c%0d: got %b want %b", c, ord_err, e_err); end
            checks++; if (m0_rdata !== s_rdata || m1_rdata !== s_rdata) begin failures++; $display("FAIL rand_rdata c%0d: got %h/%h want %h", c, m0_rdata, m1_rdata, s_rdata); end
            if (e_sreq) begin
                got_fields = {s_wr, s_size, s_addr, s_wstrb, s_wdata};
                checks++; if (got_fields !== e_fields) begin failures++; $display("FAIL rand_fields c%0d: got %h want %h", c, got_fields, e_fields); end
            end
            if (e_ao0) act0 = 1'b0;
            if (e_ao1) act1 = 1'b0;
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_single_read();
        test_lock();
        test_contention();
        test_full();
        test_ordering();
        test_errors_and_reset();
        do_reset();
        test_random();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
